// File: rtl/output_fifo_pkg.sv
// Shared constants for the output FIFO slice.
// Holds the default word width and depth used by output_fifo and its
// storage sub-module, so both agree when instantiated without overrides.
package output_fifo_pkg;

  localparam int DEF_BUS_SIZE = 32;
  localparam int DEF_DEPTH    = 16;

endpackage

// File: rtl/dff.sv
// Generic enabled register with asynchronous active-high reset to zero.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high, clears q to 0
//   en   - load enable
//   d    - next value
//   q    - registered value
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/output_fifo_mem.sv
// DEPTH x (BUS_SIZE+1) register array for the output FIFO.
// Each entry is {last, data}. One synchronous write port, one
// asynchronous read port. Every entry clears to 0 on reset.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   we       - write enable
//   waddr    - write address
//   wdata    - write entry {last, data}
//   raddr    - read address
//   rdata    - entry at raddr (combinational)
module output_fifo_mem
  import output_fifo_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BUS_SIZE:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BUS_SIZE:0] rdata
);

  logic [BUS_SIZE:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/output_fifo.sv
// Output buffer between the encoder datapath and the external data-out port.
// Captures every qualified encoder word into a DEPTH-entry FIFO and presents
// it on a valid/ready interface with an end-of-transaction marker. The encoder
// cannot be stalled, so a push into a full FIFO with no same-cycle pop is
// dropped and recorded in the sticky overflow flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous clear of pointers and occupancy (wins over push/pop)
//   din        - encoder word
//   din_valid  - push strobe
//   din_last   - final word of the transaction, sampled with din_valid
//   free_cnt   - free entries, derived from the registered occupancy
//   full/empty - occupancy at DEPTH / at 0
//   overflow   - sticky, a push was dropped; cleared only by rst
//   do_data    - head word
//   do_valid   - head word present
//   do_last    - head word's last flag
//   do_ready   - consumer accepts the head word
module output_fifo
  import output_fifo_pkg::*;
#(
  parameter int BUS_SIZE = DEF_BUS_SIZE,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [BUS_SIZE-1:0] din,
  input  logic                din_valid,
  input  logic                din_last,
  output logic [CNT_W-1:0]    free_cnt,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic [BUS_SIZE-1:0] do_data,
  output logic                do_valid,
  output logic                do_last,
  input  logic                do_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             pop, push_ok, drop;
  logic [BUS_SIZE:0] rd_entry;

  assign pop = do_valid & do_ready;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  // Pushes during flush are discarded silently, never counted as drops.
  assign push_ok = din_valid & ~flush & ((count != CNT_W'(DEPTH)) | pop);
  assign drop    = din_valid & ~flush & ~push_ok;

  always_comb begin
    wr_ptr_nxt = '0;
    rd_ptr_nxt = '0;
    count_nxt  = '0;
    if (!flush) begin
      wr_ptr_nxt = wr_ptr + AW'(push_ok);
      rd_ptr_nxt = rd_ptr + AW'(pop);
      count_nxt  = count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  dff #(.W(AW)) u_wr_ptr (
    .clk(clk), .rst(rst), .en(1'b1), .d(wr_ptr_nxt), .q(wr_ptr)
  );

  dff #(.W(AW)) u_rd_ptr (
    .clk(clk), .rst(rst), .en(1'b1), .d(rd_ptr_nxt), .q(rd_ptr)
  );

  dff #(.W(CNT_W)) u_count (
    .clk(clk), .rst(rst), .en(1'b1), .d(count_nxt), .q(count)
  );

  dff #(.W(1)) u_overflow (
    .clk(clk), .rst(rst), .en(drop), .d(1'b1), .q(overflow)
  );

  output_fifo_mem #(
    .BUS_SIZE(BUS_SIZE),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (push_ok),
    .waddr(wr_ptr),
    .wdata({din_last, din}),
    .raddr(rd_ptr),
    .rdata(rd_entry)
  );

  assign free_cnt = CNT_W'(DEPTH) - count;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_valid = (count != '0);
  assign do_data  = rd_entry[BUS_SIZE-1:0];
  assign do_last  = rd_entry[BUS_SIZE];

endmodule

// File: tb/tb_output_fifo.sv
module tb_output_fifo;

  localparam int BUS_SIZE = 32;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic [BUS_SIZE-1:0] din;
  logic                din_valid;
  logic                din_last;
  logic [CNT_W-1:0]    free_cnt;
  logic                full;
  logic                empty;
  logic                overflow;
  logic [BUS_SIZE-1:0] do_data;
  logic                do_valid;
  logic                do_last;
  logic                do_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered list of buffered {last, data} entries.
  logic [BUS_SIZE:0] model_q [$];
  logic              model_ovf;

  always #5 clk = ~clk;

  output_fifo #(.BUS_SIZE(BUS_SIZE), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .din      (din),
    .din_valid(din_valid),
    .din_last (din_last),
    .free_cnt (free_cnt),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .do_data  (do_data),
    .do_valid (do_valid),
    .do_last  (do_last),
    .do_ready (do_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic step(input logic v, input logic [BUS_SIZE-1:0] d, input logic l,
                      input logic r, input logic f);
    int sz;
    din_valid = v; din = d; din_last = l; do_ready = r; flush = f;
    #1;
    sz = model_q.size();
    check("do_valid", 64'(do_valid), 64'(sz != 0));
    check("free_cnt", 64'(free_cnt), 64'(DEPTH - sz));
    check("full",     64'(full),     64'(sz == DEPTH));
    check("empty",    64'(empty),    64'(sz == 0));
    check("overflow", 64'(overflow), 64'(model_ovf));
    if (sz != 0) begin
      check("do_data", 64'(do_data), 64'(model_q[0][BUS_SIZE-1:0]));
      check("do_last", 64'(do_last), 64'(model_q[0][BUS_SIZE]));
    end
    if (f) begin
      model_q.delete();
    end else begin
      if (r && sz != 0) void'(model_q.pop_front());
      if (v) begin
        if (model_q.size() < DEPTH) model_q.push_back({l, d});
        else model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do_valid"}, 64'(do_valid), 64'(0));
    check({tag, "_do_data"},  64'(do_data),  64'(0));
    check({tag, "_do_last"},  64'(do_last),  64'(0));
    check({tag, "_free_cnt"}, 64'(free_cnt), 64'(DEPTH));
    check({tag, "_full"},     64'(full),     64'(0));
    check({tag, "_empty"},    64'(empty),    64'(1));
    check({tag, "_overflow"}, 64'(overflow), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0; din = '0; din_last = 1'b0; do_ready = 1'b0; flush = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  initial begin
    model_ovf = 1'b0;
    rst = 1'b1;
    din_valid = 1'b0; din = '0; din_last = 1'b0; do_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 10 words with the consumer stalled, then drain in order.
    for (int i = 1; i <= 10; i++) step(1'b1, 32'(i), (i == 10), 1'b0, 1'b0);
    #1;
    check("ten_free_cnt", 64'(free_cnt), 64'(6));
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Full FIFO: simultaneous push and pop must be accepted.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000ABCD, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Overflow: one push beyond capacity is dropped.
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, $urandom_range(0, 1), 1'b0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Flush with a concurrent push; overflow stays as it was.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Sustained streaming with the consumer always ready.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, $urandom_range(0, 1), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Random traffic, including occasional flushes.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 8; i++) step(1'b1, $urandom | 32'h1, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_fifo.md
# output_fifo

Output buffer between the encoder datapath and the external data-out port. Captures every word the encoder qualifies with `data_out_valid` into a `DEPTH`-entry FIFO and presents it on a valid/ready interface with an end-of-transaction marker. Reports free space so the mode controller launches a header+block burst only when the whole burst fits. The encoder has no backpressure input, so this block absorbs external stalls.

## Interface
- `BUS_SIZE`, 32, word width; equals the encoder's bus width.
- `DEPTH`, 16, number of entries; power of two, ≥ 10 (one block of 8 words plus header plus status).
- `CNT_W` (localparam), log2(`DEPTH`)+1, width of occupancy and free-space counters.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous clear of the FIFO contents.
- `din`  in  `BUS_SIZE`  word from the encoder's `data_out`.
- `din_valid`  in  1  push strobe from the encoder's `data_out_valid`.
- `din_last`  in  1  marks `din` as the final word of the output transaction; sampled with `din_valid`.
- `free_cnt`  out  `CNT_W`  number of free entries (registered).
- `full`  out  1  `free_cnt` == 0.
- `empty`  out  1  `free_cnt` == `DEPTH`.
- `overflow`  out  1  sticky flag: a push was dropped.
- `do_data`  out  `BUS_SIZE`  head word.
- `do_valid`  out  1  head word is present.
- `do_last`  out  1  head word carries `din_last`.
- `do_ready`  in  1  external consumer accepts the head word.

## Operation
- Storage holds `DEPTH` entries of `BUS_SIZE`+1 bits: the data word and its last flag. Each entry resets to 0.
- Write pointer, read pointer, and occupancy `count` are registers. Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. `count` is `CNT_W` bits and ranges 0..`DEPTH`.
- **pop**: `do_valid & do_ready`. Advances the read pointer.
- **push request**: `din_valid`.
- **Push acceptance**: a push is accepted when `count` < `DEPTH`, or when `count` == `DEPTH` and a pop occurs in the same cycle. Accepting a push writes the entry at the write pointer and advances it.
- **Dropped push**: a push request that is not accepted leaves the storage unchanged and sets `overflow`. `overflow` clears only on `rst`; `flush` does not clear it.
- `count` next value = `count` + accepted push − pop. A simultaneous push and pop leaves `count` unchanged.
- `free_cnt` = `DEPTH` − `count`. `full` and `empty` derive from the registered `count`.
- `do_valid` = (`count` != 0). `do_data` and `do_last` read the entry at the read pointer combinationally. When `do_valid` = 0 they are don't-care for the consumer.
- **flush** has priority over push and pop in the same cycle. It zeroes both pointers and `count`; storage contents are left as they are. Any push in the flush cycle is discarded and does not set `overflow`.
- Popping when empty cannot occur, because `do_valid` = 0.
- The block performs no data transformation. The validity masking is already applied upstream.

## Timing
- Reset values: `do_valid` 0, `do_data` 0, `do_last` 0, `free_cnt` = `DEPTH`, `full` 0, `empty` 1, `overflow` 0.
- Latency: a word pushed in cycle t into an empty FIFO appears with `do_valid` = 1 in cycle t+1.
- `free_cnt` updates one cycle after the push or pop that changes it.
- Mode controller rule: a burst of k words starts only if `free_cnt` ≥ k at the burst's first cycle. Pops during the burst only add space.
- Handshake: once asserted, `do_valid` stays high and `do_data`/`do_last` stay stable until the pop, unless `flush` or `rst` occurs.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-transfer: all outputs return asynchronously to their reset values; buffered words are lost.

## Structure
- Shared package: none required. `CNT_W` is derived locally with `$clog2`.
- Pointer and count registers use the codebase `dff` with asynchronous reset enabled.
- One sub-module: `output_fifo_mem`, the `DEPTH` × (`BUS_SIZE`+1) register array with a write port and an asynchronous read port, reset to 0.
- Control logic (pointers, count, flags) stays in `output_fifo`.

## Test plan
- Reset, then 10 pushes of 0x00000001..0x0000000A, the last with `din_last` = 1, while `do_ready` = 0 → `free_cnt` = 6. Then hold `do_ready` = 1 → 10 words out in order, `do_last` = 1 only on 0x0000000A, then `empty` = 1.
- Fill 16 entries, then push once more with `do_ready` = 0 → word dropped, `overflow` = 1, `free_cnt` = 0. Drain → exactly 16 original words.
- With the FIFO full, push and pop in the same cycle → push accepted, `count` stays 16, `overflow` stays 0, and the new word is emitted 16th after the popped one.
- Continuous push/pop for 40 cycles with `do_ready` = 1 → `do_valid` high from cycle 2, `free_cnt` constant at 15, pointers wrap twice, no data loss.
- 5 words buffered, then `flush` asserted together with `din_valid` → next cycle `empty` = 1, `free_cnt` = 16, `overflow` unchanged.
- Assert `rst` mid-drain → all outputs immediately return to their reset values without waiting for a clock edge.
